// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter
//   Captures four request lines into sticky pending bits and grants the
//   highest-priority pending request (bit 3 highest) through a registered
//   valid/ready output slot. A request leaves "pending" when it is loaded
//   into the output slot. A capture that lands on an already-pending bit
//   is reported as a one-cycle overrun pulse.
//
//   Optional build macro: IRQ_PENDING_ARBITER_MASK_EN adds the mask_i port.
//   Masked bits still capture, stay pending and report overrun, but are never
//   selected.
//
// Parameters
//   EDGE_DET     1 = capture on a 0->1 transition of req_i, 0 = capture on level
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   req_i[3:0]   request lines
//   mask_i[3:0]  (macro only) 1 = bit not eligible for selection
//   out_ready_i  consumer accepts the held grant
//   out_valid_o  out_idx_o holds a granted request
//   out_idx_o    index of the granted request
//   pending_o    sticky pending bits, excluding the one in the output slot
//   overrun_o    one-cycle pulse per bit on a capture into a pending bit

// One request bit: input history, sticky pending flag and overrun pulse.
module irq_pending_lane #(
    parameter int unsigned EDGE_DET = 1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic req_i,
    input  logic clr_i,
    output logic pending_o,
    output logic overrun_o
);
    logic req_q, pend_q, ovr_q;
    logic set, pend_d, ovr_d;

    assign set    = (EDGE_DET != 0) ? (req_i & ~req_q) : req_i;
    // A capture coinciding with the bit's own grant wins: the bit re-arms.
    assign pend_d = (pend_q & ~clr_i) | set;
    assign ovr_d  = set & pend_q & ~clr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            req_q  <= req_i;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pending_o = pend_q;
    assign overrun_o = ovr_q;
endmodule

module irq_pending_arbiter #(
    parameter int unsigned EDGE_DET = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
`ifdef IRQ_PENDING_ARBITER_MASK_EN
    input  logic [3:0] mask_i,
`endif
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output logic [1:0] out_idx_o,
    output logic [3:0] pending_o,
    output logic [3:0] overrun_o
);
    localparam int NUM_REQ = 4;

    logic [NUM_REQ-1:0] pend, ovr, elig, clr, mask_eff;
    logic [1:0]         sel;
    logic               any, load_en;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_idx_q, out_idx_d;

`ifdef IRQ_PENDING_ARBITER_MASK_EN
    assign mask_eff = mask_i;
`else
    assign mask_eff = '0;
`endif

    assign elig    = pend & ~mask_eff;
    assign any     = |elig;
    // The slot can take a new grant when empty or being drained this edge.
    assign load_en = !out_valid_q || out_ready_i;

    // Ascending scan so the highest eligible bit is the last one written.
    always_comb begin
        sel = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[i]) sel = 2'(i);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        clr         = '0;
        if (load_en) begin
            out_valid_d = any;
            if (any) begin
                out_idx_d = sel;
                clr       = NUM_REQ'(1) << sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= 2'b00;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        irq_pending_lane #(.EDGE_DET(EDGE_DET)) u_lane (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .req_i     (req_i[g]),
            .clr_i     (clr[g]),
            .pending_o (pend[g]),
            .overrun_o (ovr[g])
        );
    end

    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign pending_o   = pend;
    assign overrun_o   = ovr;
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Bench for irq_pending_arbiter: a directed vector table, a few hand-written
// corner sequences, then random traffic against a reference model. An
// edge-capture and a level-capture instance run side by side.
module tb_irq_pending_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       rdy;
    logic       vld_e, vld_l;
    logic [1:0] idx_e, idx_l;
    logic [3:0] pend_e, pend_l, ovr_e, ovr_l;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_pending_arbiter #(.EDGE_DET(1)) dut_e (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
`ifdef IRQ_PENDING_ARBITER_MASK_EN
        .mask_i(mask),
`endif
        .out_ready_i(rdy), .out_valid_o(vld_e), .out_idx_o(idx_e),
        .pending_o(pend_e), .overrun_o(ovr_e)
    );

    irq_pending_arbiter #(.EDGE_DET(0)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
`ifdef IRQ_PENDING_ARBITER_MASK_EN
        .mask_i(mask),
`endif
        .out_ready_i(rdy), .out_valid_o(vld_l), .out_idx_o(idx_l),
        .pending_o(pend_l), .overrun_o(ovr_l)
    );

    // Reference model: a pending set, one output slot and the last req value.
    typedef struct {
        logic [3:0] reqq;
        logic [3:0] pend;
        logic [3:0] ovr;
        logic       vld;
        logic [1:0] idx;
    } mst_t;

    mst_t me, ml;

    function automatic mst_t mstep(mst_t s, logic rst, logic [3:0] r, logic rd,
                                   logic [3:0] msk, bit edge_mode);
        mst_t n;
        int   g;
        bit   cap;
        n = s;
        if (!rst) begin
            n.reqq = '0; n.pend = '0; n.ovr = '0; n.vld = 1'b0; n.idx = 2'b00;
            return n;
        end
        g = -1;
        if (!s.vld || rd) begin
            for (int i = 0; i < 4; i++)
                if (s.pend[i] && !msk[i]) g = i;
            n.vld = (g >= 0);
            if (g >= 0) n.idx = g[1:0];
        end
        for (int i = 0; i < 4; i++) begin
            cap       = edge_mode ? (r[i] && !s.reqq[i]) : r[i];
            n.ovr[i]  = cap && s.pend[i] && (g != i);
            n.pend[i] = (s.pend[i] && (g != i)) || cap;
        end
        n.reqq = r;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: model advances on the same inputs, both DUTs compared after.
    task automatic tick();
        logic [3:0] m;
        @(posedge clk);
`ifdef IRQ_PENDING_ARBITER_MASK_EN
        m = mask;
`else
        m = 4'b0000;
`endif
        me = mstep(me, rst_n, req, rdy, m, 1'b1);
        ml = mstep(ml, rst_n, req, rdy, m, 1'b0);
        #1;
        chk("model edge", {21'd0, vld_e, idx_e, pend_e, ovr_e},
            {21'd0, me.vld, me.idx, me.pend, me.ovr});
        chk("model level", {21'd0, vld_l, idx_l, pend_l, ovr_l},
            {21'd0, ml.vld, ml.idx, ml.pend, ml.ovr});
    endtask

    task automatic chk_e(input string nm, input logic v, input logic [1:0] ix,
                         input logic [3:0] p, input logic [3:0] o);
        chk({nm, " valid"},   {31'd0, vld_e}, {31'd0, v});
        chk({nm, " idx"},     {30'd0, idx_e}, {30'd0, ix});
        chk({nm, " pending"}, {28'd0, pend_e}, {28'd0, p});
        chk({nm, " overrun"}, {28'd0, ovr_e}, {28'd0, o});
    endtask

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic       vld;
        logic [1:0] idx;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl[32];

    initial begin
        tbl[0]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 2'd2, 4'b1011, 4'b0000};
        tbl[6]  = '{1'b1, 4'b1011, 1'b1, 1'b1, 2'd3, 4'b0011, 4'b0000};
        tbl[7]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0001, 4'b0000};
        tbl[8]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        // stall: first grant holds while a higher bit arrives
        tbl[10] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000};
        tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[13] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b1000, 4'b0000};
        tbl[14] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1000, 4'b0000};
        tbl[15] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[16] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000};
        // overrun on bit 2 while stalled
        tbl[17] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd3, 4'b0001, 4'b0000};
        tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[19] = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'd0, 4'b0100, 4'b0000};
        tbl[20] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0100, 4'b0000};
        tbl[21] = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'd0, 4'b0100, 4'b0100};
        tbl[22] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0100, 4'b0000};
        tbl[23] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000};
        tbl[24] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000};
        // bit 1 loaded on the same edge as a fresh bit-1 capture
        tbl[25] = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'd2, 4'b0001, 4'b0000};
        tbl[26] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[27] = '{1'b1, 4'b0010, 1'b0, 1'b1, 2'd0, 4'b0010, 4'b0000};
        tbl[28] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0010, 4'b0000};
        tbl[29] = '{1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 4'b0000};
        tbl[30] = '{1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 4'b0000};
        tbl[31] = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000};

        rst_n = 1'b0; req = '0; rdy = 1'b1; mask = '0;
        me = mstep(me, 1'b0, 4'b0, 1'b0, 4'b0, 1'b1);
        ml = mstep(ml, 1'b0, 4'b0, 1'b0, 4'b0, 1'b0);

        for (int k = 0; k < 32; k++) begin
            rst_n = tbl[k].rst_n; req = tbl[k].req; rdy = tbl[k].rdy;
            tick();
            chk_e($sformatf("vec%0d", k), tbl[k].vld, tbl[k].idx, tbl[k].pend, tbl[k].ovr);
        end

        // reset while stalled with a held grant and a pending bit
        rdy = 1'b0; req = 4'b0001; tick();
        req = 4'b0000; tick();
        req = 4'b0100; tick();
        chk_e("pre-reset stall", 1'b1, 2'd0, 4'b0100, 4'b0000);
        rst_n = 1'b0; tick();
        chk_e("mid-stall reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
        // req held high across reset release counts as an edge
        rst_n = 1'b1; rdy = 1'b1; tick();
        chk_e("held across release", 1'b0, 2'd0, 4'b0100, 4'b0000);
        tick();
        chk_e("held grant", 1'b1, 2'd2, 4'b0000, 4'b0000);
        req = 4'b0000; tick();
        chk_e("held drained", 1'b0, 2'd2, 4'b0000, 4'b0000);

`ifdef IRQ_PENDING_ARBITER_MASK_EN
        mask = 4'b1000; req = 4'b1001; tick();
        chk_e("mask capture", 1'b0, 2'd2, 4'b1001, 4'b0000);
        req = 4'b0000; tick();
        chk_e("mask grant0", 1'b1, 2'd0, 4'b1000, 4'b0000);
        tick();
        chk_e("mask retain", 1'b0, 2'd0, 4'b1000, 4'b0000);
        mask = 4'b0000; tick();
        chk_e("unmask grant3", 1'b1, 2'd3, 4'b0000, 4'b0000);
        tick();
`endif

        // random traffic, compared against the model inside tick()
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int b = 0; b < 4; b++) begin
                req[b]  = ($urandom_range(0, 9) < 3);
                mask[b] = ($urandom_range(0, 3) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
